// File: rtl/seg7_pkg.sv
// Shared constants, state type and helpers for the seven-segment capture block.
package seg7_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned CNT_W   = 8;

    // Segment patterns {g,f,e,d,c,b,a}, active-high
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h67;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // Expected successor of a decimal digit, wrapping 9 -> 0
    function automatic logic [DIGIT_W-1:0] next_digit(input logic [DIGIT_W-1:0] d);
        return (d == DIGIT_W'(9)) ? DIGIT_W'(0) : DIGIT_W'(d + DIGIT_W'(1));
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational pattern decoder: flags legal digits and blank, returns digit value.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0]   pattern_i,
    output logic               legal_o,
    output logic               blank_o,
    output logic [DIGIT_W-1:0] digit_o
);

    // Table lookup; anything not listed is illegal
    always_comb begin
        legal_o = 1'b1;
        blank_o = 1'b0;
        digit_o = '0;
        case (pattern_i)
            SEG_0:     digit_o = DIGIT_W'(0);
            SEG_1:     digit_o = DIGIT_W'(1);
            SEG_2:     digit_o = DIGIT_W'(2);
            SEG_3:     digit_o = DIGIT_W'(3);
            SEG_4:     digit_o = DIGIT_W'(4);
            SEG_5:     digit_o = DIGIT_W'(5);
            SEG_6:     digit_o = DIGIT_W'(6);
            SEG_7:     digit_o = DIGIT_W'(7);
            SEG_8:     digit_o = DIGIT_W'(8);
            SEG_9:     digit_o = DIGIT_W'(9);
            SEG_BLANK: begin
                legal_o = 1'b0;
                blank_o = 1'b1;
            end
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Debounced capture of an asynchronous seven-segment bus with sequence checking.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SEG_W-1:0]   seg_in,
    output logic [DIGIT_W-1:0] digit,
    output logic               digit_valid,
    output logic               new_digit,
    output logic               seq_error,
    output logic               bad_pattern,
    output logic [CNT_W-1:0]   seq_err_count,
    output logic [CNT_W-1:0]   bad_count,
    output logic               locked
);

    localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [SEG_W-1:0]   sync1_q, sync2_q;
    state_e             state_q, state_d;
    logic [SEG_W-1:0]   cand_q, cand_d;
    logic [SEG_W-1:0]   accepted_q, accepted_d;
    logic [CNT_W-1:0]   count_q, count_d, count_inc;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               valid_q, valid_d;
    logic               new_digit_q, new_digit_d;
    logic               seq_error_q, seq_error_d;
    logic               bad_q, bad_d;
    logic [CNT_W-1:0]   seq_cnt_q, seq_cnt_d;
    logic [CNT_W-1:0]   bad_cnt_q, bad_cnt_d;
    logic               locked_q, locked_d;
    logic               accept;
    logic               dec_legal, dec_blank;
    logic [DIGIT_W-1:0] dec_digit;

    seg7_decode u_decode (
        .pattern_i (cand_q),
        .legal_o   (dec_legal),
        .blank_o   (dec_blank),
        .digit_o   (dec_digit)
    );

    assign count_inc = CNT_W'(count_q + CNT_W'(1));

    // Two-flop synchronizer for the asynchronous segment bus
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= seg_in;
            sync2_q <= sync1_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cand_q      <= SEG_BLANK;
            accepted_q  <= SEG_BLANK;
            count_q     <= '0;
            digit_q     <= '0;
            valid_q     <= 1'b0;
            new_digit_q <= 1'b0;
            seq_error_q <= 1'b0;
            bad_q       <= 1'b0;
            seq_cnt_q   <= '0;
            bad_cnt_q   <= '0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            accepted_q  <= accepted_d;
            count_q     <= count_d;
            digit_q     <= digit_d;
            valid_q     <= valid_d;
            new_digit_q <= new_digit_d;
            seq_error_q <= seq_error_d;
            bad_q       <= bad_d;
            seq_cnt_q   <= seq_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            locked_q    <= locked_d;
        end
    end

    // Stability FSM plus acceptance side effects (digit update, strobes, counters)
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        accepted_d  = accepted_q;
        count_d     = count_q;
        digit_d     = digit_q;
        valid_d     = valid_q;
        new_digit_d = 1'b0;
        seq_error_d = 1'b0;
        bad_d       = 1'b0;
        seq_cnt_d   = seq_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        accept      = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = SETTLE;
                cand_d  = sync2_q;
                count_d = CNT_W'(1);
            end
            SETTLE: begin
                if (sync2_q != cand_q) begin
                    cand_d  = sync2_q;
                    count_d = CNT_W'(1);
                end else if (count_inc == STABLE_N) begin
                    state_d = LOCKED;
                    count_d = count_inc;
                    accept  = 1'b1;
                end else begin
                    count_d = count_inc;
                end
            end
            LOCKED: begin
                if (sync2_q != accepted_q) begin
                    state_d = SETTLE;
                    cand_d  = sync2_q;
                    count_d = CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Re-accepting the same pattern (e.g. after a glitch) is silent
        if (accept && (cand_q != accepted_q)) begin
            accepted_d = cand_q;
            if (dec_blank) begin
                valid_d = 1'b0;
            end else if (dec_legal) begin
                digit_d     = dec_digit;
                valid_d     = 1'b1;
                new_digit_d = 1'b1;
                if (valid_q && (dec_digit != next_digit(digit_q))) begin
                    seq_error_d = 1'b1;
                    if (seq_cnt_q != CNT_MAX) begin
                        seq_cnt_d = CNT_W'(seq_cnt_q + CNT_W'(1));
                    end
                end
            end else begin
                bad_d = 1'b1;
                if (bad_cnt_q != CNT_MAX) begin
                    bad_cnt_d = CNT_W'(bad_cnt_q + CNT_W'(1));
                end
            end
        end

        locked_d = (state_d == LOCKED);
    end

    assign digit         = digit_q;
    assign digit_valid   = valid_q;
    assign new_digit     = new_digit_q;
    assign seq_error     = seq_error_q;
    assign bad_pattern   = bad_q;
    assign seq_err_count = seq_cnt_q;
    assign bad_count     = bad_cnt_q;
    assign locked        = locked_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed self-checking bench for seg7_capture.
module tb_seg7_capture;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg_in;
    logic [3:0] digit;
    logic       digit_valid, new_digit, seq_error, bad_pattern, locked;
    logic [7:0] seq_err_count, bad_count;

    int checks = 0;
    int fails  = 0;

    // Pulse bookkeeping over the current observation window
    int cyc, nd, se, bp, coin, first_nd, first_lock;

    logic [6:0] legal_pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};
    logic [6:0] bad_pat   [8]  = '{7'h01, 7'h02, 7'h04, 7'h08,
                                   7'h10, 7'h20, 7'h40, 7'h03};

    seg7_capture #(.STABLE_CYCLES(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .seg_in        (seg_in),
        .digit         (digit),
        .digit_valid   (digit_valid),
        .new_digit     (new_digit),
        .seq_error     (seq_error),
        .bad_pattern   (bad_pattern),
        .seq_err_count (seq_err_count),
        .bad_count     (bad_count),
        .locked        (locked)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cyc = 0; nd = 0; se = 0; bp = 0; coin = 0; first_nd = 0; first_lock = 0;
    endtask

    // Advance n clock edges, sampling on the falling edge after each
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (new_digit) begin
                nd++;
                if (first_nd == 0) first_nd = cyc;
                if (seq_error) coin++;
            end
            if (seq_error) se++;
            if (bad_pattern) bp++;
            if (locked && first_lock == 0) first_lock = cyc;
        end
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg_in = p;
        tick(n);
    endtask

    initial begin
        reset  = 1'b1;
        seg_in = 7'h3F;
        clr();
        tick(3);
        check("rst_digit", 32'(digit), 32'd0);
        check("rst_valid", 32'(digit_valid), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_strobes", 32'({new_digit, seq_error, bad_pattern}), 32'd0);
        check("rst_counts", 32'({seq_err_count, bad_count}), 32'd0);

        // First acceptance latency: 2 sync + 16 stable cycles
        reset = 1'b0;
        clr();
        tick(20);
        check("lat_pulses", 32'(nd), 32'd1);
        check("lat_cycle", 32'(first_nd), 32'd18);
        check("lat_lock_cycle", 32'(first_lock), 32'd18);
        check("lat_digit", 32'(digit), 32'd0);
        check("lat_valid", 32'(digit_valid), 32'd1);
        check("lat_locked", 32'(locked), 32'd1);

        // Full ascending sequence 1..9 then wrap to 0
        for (int i = 1; i <= 10; i++) hold(legal_pat[i % 10], 30);
        check("seq_pulses", 32'(nd), 32'd11);
        check("seq_wrap_digit", 32'(digit), 32'd0);
        check("seq_no_err", 32'(se), 32'd0);
        check("seq_err_cnt0", 32'(seq_err_count), 32'd0);

        // 1 followed by 3 breaks the sequence
        hold(7'h06, 30);
        clr();
        hold(7'h4F, 30);
        check("skip_nd", 32'(nd), 32'd1);
        check("skip_se", 32'(se), 32'd1);
        check("skip_coincident", 32'(coin), 32'd1);
        check("skip_cnt", 32'(seq_err_count), 32'd1);
        check("skip_digit", 32'(digit), 32'd3);

        // Lock on 2 (3 -> 2 is another sequence error), then a short glitch
        hold(7'h5B, 30);
        check("two_cnt", 32'(seq_err_count), 32'd2);
        check("two_digit", 32'(digit), 32'd2);
        clr();
        hold(7'h7F, 5);
        check("glitch_unlock", 32'(locked), 32'd0);
        hold(7'h5B, 30);
        check("glitch_strobes", 32'(nd + se + bp), 32'd0);
        check("glitch_digit", 32'(digit), 32'd2);
        check("glitch_relock", 32'(locked), 32'd1);

        // Illegal pattern leaves digit and history alone
        clr();
        hold(7'h01, 30);
        check("bad_once", 32'(bp), 32'd1);
        check("bad_cnt1", 32'(bad_count), 32'd1);
        check("bad_no_nd", 32'(nd), 32'd0);
        check("bad_digit", 32'(digit), 32'd2);
        check("bad_valid", 32'(digit_valid), 32'd1);

        // Legal/illegal alternation drives both counters into saturation
        for (int i = 0; i < 100; i++) begin
            hold(7'h3F, 20);
            hold(bad_pat[i % 8], 20);
        end
        check("bad_cnt101", 32'(bad_count), 32'd101);
        check("seq_cnt102", 32'(seq_err_count), 32'd102);
        for (int i = 100; i < 300; i++) begin
            hold(7'h3F, 20);
            hold(bad_pat[i % 8], 20);
        end
        check("bad_cnt_sat", 32'(bad_count), 32'd255);
        check("seq_cnt_sat", 32'(seq_err_count), 32'd255);

        // Blank clears validity and history; next digit is not a sequence error
        clr();
        hold(7'h00, 30);
        check("blank_valid", 32'(digit_valid), 32'd0);
        check("blank_digit_hold", 32'(digit), 32'd0);
        check("blank_strobes", 32'(nd + se + bp), 32'd0);
        hold(7'h5B, 30);
        check("after_blank_nd", 32'(nd), 32'd1);
        check("after_blank_se", 32'(se), 32'd0);
        check("after_blank_digit", 32'(digit), 32'd2);

        // Reset in the middle of settling on 4
        seg_in = 7'h66;
        tick(12);
        check("mid_settle_unlocked", 32'(locked), 32'd0);
        reset = 1'b1;
        clr();
        tick(1);
        check("mrst_digit", 32'(digit), 32'd0);
        check("mrst_valid", 32'(digit_valid), 32'd0);
        check("mrst_counts", 32'({seq_err_count, bad_count}), 32'd0);
        check("mrst_locked", 32'(locked), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(1);
        check("mrst_no_strobe", 32'(nd + se + bp), 32'd0);
        clr();
        tick(16);
        check("reacq_early", 32'(nd), 32'd0);
        tick(4);
        check("reacq_nd", 32'(nd), 32'd1);
        check("reacq_cycle", 32'(first_nd), 32'd17);
        check("reacq_digit", 32'(digit), 32'd4);
        check("reacq_se", 32'(se), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 16, consecutive identical synchronized samples required to accept a pattern (legal 2..255).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 seg_in  input  7  asynchronous segment bus {g,f,e,d,c,b,a}, active-high.
REQ-005 digit  output  4  last accepted decoded digit 0..9.
REQ-006 digit_valid  output  1  high while digit holds a decoded value; low after reset or blank.
REQ-007 new_digit  output  1  one-cycle strobe on acceptance of a changed legal digit pattern.
REQ-008 seq_error  output  1  one-cycle strobe when an accepted digit is not predecessor+1 mod 10.
REQ-009 bad_pattern  output  1  one-cycle strobe when an accepted non-blank pattern is not in the digit table.
REQ-010 seq_err_count  output  8  saturating count of seq_error strobes.
REQ-011 bad_count  output  8  saturating count of bad_pattern strobes.
REQ-012 locked  output  1  high while state is LOCKED.

Function
REQ-013 Digit table: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7C, 7=0x07, 8=0x7F, 9=0x67; blank=0x00.
REQ-014 seg_in passes a 2-flop synchronizer; all further logic uses synchronized sample s.
REQ-015 States: IDLE (post-reset), SETTLE (candidate held, counting), LOCKED (candidate accepted, equals s).
REQ-016 IDLE -> SETTLE next cycle, loading candidate=s, stable count=1.
REQ-017 SETTLE: s==candidate increments count; s!=candidate reloads candidate=s, count=1; count reaching STABLE_CYCLES -> accept, go LOCKED.
REQ-018 LOCKED: s!=accepted pattern -> SETTLE with candidate=s, count=1; locked drops that same cycle.
REQ-019 Acceptance of a pattern equal to the previously accepted pattern produces no strobe and no output change.
REQ-020 Accepting legal digit d: digit=d, digit_valid=1, new_digit=1 for one cycle, all registered on the accept edge.
REQ-021 Sequence check applies only when a prior legal digit p exists since last reset/blank: d != (p==9 ? 0 : p+1) -> seq_error with new_digit same cycle.
REQ-022 Accepting blank: digit_valid=0, digit holds, no strobes, sequence history cleared.
REQ-023 Accepting illegal pattern: bad_pattern strobe; digit, digit_valid and sequence history unchanged.
REQ-024 Counters increment with their strobe and saturate at 255, never wrapping.
REQ-025 Latency seg_in change to strobe: 2 sync cycles + STABLE_CYCLES cycles, given stable input.
REQ-026 Glitch shorter than STABLE_CYCLES samples leaves outputs unchanged; LOCKED re-entry on the original pattern produces no strobe.

Reset
REQ-027 Reset forces state IDLE, synchronizer and candidate 0x00, count 0, digit=0, digit_valid=0, all strobes 0, both counters 0, locked=0, history cleared.
REQ-028 Reset asserted mid-SETTLE or mid-strobe takes priority; no strobe is emitted on the reset edge or the following cycle.

Structure
REQ-029 Package seg7_pkg holds the digit-table constants, blank constant, and state enum typedef.
REQ-030 Combinational sub-module seg7_decode maps 7-bit pattern to {legal, blank, digit[3:0]}; seg7_capture instantiates it once.

Verification
REQ-031 Reset, hold seg_in=0x3F 20 cycles -> new_digit single pulse at cycle 18 after release, digit=0, digit_valid=1, locked=1.
REQ-032 Sequence 0x3F,0x06,...,0x67,0x3F each held 30 cycles -> 11 new_digit pulses, digit wraps 9->0, seq_err_count=0.
REQ-033 Locked on 0x06, then 0x4F (3) -> seq_error and new_digit same cycle, seq_err_count=1, digit=3.
REQ-034 Locked on 0x5B, 5-cycle glitch to 0x7F -> no strobes, digit stays 2, locked returns high.
REQ-035 Apply 0x01 for 30 cycles -> bad_pattern once, bad_count=1, digit unchanged; repeat 300 distinct illegal/legal alternations -> bad_count=255.
REQ-036 Assert reset during SETTLE on 0x66 at count 10 -> all outputs at reset values, no strobe, re-acceptance needs full 2+STABLE_CYCLES.
